mbox_cyc_arb: RTL and testbench
===============================

MBOX_CYC_ARB -- requirements
Module: mbox_cyc_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter RR_MODE, default 1; 0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-003 Parameter TMO_W, default 8, width of the cycle-timeout counter.
REQ-004 Parameter RETRY_DLY, default 2, back-off cycles after a retry (1..15).
REQ-005 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 req  in  NREQ  per-requester cycle request; level, held by the requester until granted.
REQ-009 cycDone  in  1  one-cycle pulse: the granted MBOX cycle has completed.
REQ-010 retry  in  1  one-cycle pulse: the granted cycle must be abandoned and reissued.
REQ-011 tmoLimit  in  TMO_W  timeout threshold in cycles; 0 disables the timeout.
REQ-012 grant  out  NREQ  one-hot grant, registered.
REQ-013 grantIdx  out  clog2(NREQ)  encoded index of the granted requester; valid only while cycActive.
REQ-014 cycActive  out  1  a grant is outstanding.
REQ-015 tmoErr  out  1  one-cycle pulse on cycle timeout.

Function
REQ-016 The FSM SHALL have the states IDLE, BUSY and BACKOFF.
REQ-017 IDLE: if any req bit is set, the block SHALL select a winner combinationally and register grant, grantIdx and cycActive=1 at the next edge, entering BUSY; grant latency is 1 cycle.
REQ-018 RR_MODE=0: the winner SHALL be the lowest set req index.
REQ-019 RR_MODE=1: the winner SHALL be the first set req at or after rrPtr, searching upward with wrap-around modulo NREQ.
REQ-020 rrPtr SHALL advance to (winner+1) mod NREQ only on a successful cycDone; it SHALL hold on retry and on timeout.
REQ-021 BUSY: grant SHALL be held regardless of req deasserting, until cycDone, retry or timeout.
REQ-022 BUSY + cycDone: the block SHALL clear grant and go to IDLE; re-arbitration needs at least one IDLE cycle, so two grants are never back-to-back.
REQ-023 BUSY + retry without cycDone: the block SHALL clear grant, remember the retry index, load the back-off counter with RETRY_DLY and enter BACKOFF.
REQ-024 cycDone and retry in the same cycle: cycDone SHALL win and retry is ignored.
REQ-025 BACKOFF: the counter SHALL decrement each cycle; at 0 the block SHALL go to IDLE with a retry-priority flag set.
REQ-026 With the retry-priority flag set, the remembered index SHALL win the next arbitration if its req is set, overriding both modes; the flag SHALL clear on that arbitration whatever the outcome.
REQ-027 Timeout counter: it SHALL clear on entering BUSY and increment each BUSY cycle, saturating at all-ones.
REQ-028 If tmoLimit≠0 and the counter reaches tmoLimit with no cycDone or retry in that cycle, the block SHALL pulse tmoErr, clear grant and go to IDLE without retry priority.
REQ-029 cycDone or retry arriving while not BUSY SHALL be ignored.
REQ-030 grant SHALL never have more than one bit set; grant=0 SHALL hold whenever cycActive=0.

Reset
REQ-031 While rst_n=0 the following SHALL hold: state=IDLE, grant=0, grantIdx=0, cycActive=0, tmoErr=0, rrPtr=0, retry-priority flag=0, all counters=0.
REQ-032 Deassertion of reset during an outstanding cycle SHALL abandon that cycle silently; a cycDone pulse arriving after reset SHALL be ignored.

Verification
REQ-033 Round-robin order: NREQ=4, RR_MODE=1, req=4'b1111 held, cycDone 2 cycles after each grant -> grants in the order 0,1,2,3,0, with one IDLE cycle between grants.
REQ-034 Fixed priority: RR_MODE=0, req=4'b1010 -> grant=4'b0010; after cycDone, req=4'b1000 -> grant=4'b1000.
REQ-035 Retry: grant to 2, retry pulse with req=4'b0101 also set -> grant=0 for RETRY_DLY+1 cycles, then grant=4'b0100 ahead of requester 0.
REQ-036 Simultaneous done/retry: cycDone=retry=1 on the same cycle -> IDLE entered, no BACKOFF, rrPtr advanced.
REQ-037 Timeout: tmoLimit=5, no cycDone -> tmoErr pulses exactly once 5 cycles after grant, grant clears, rrPtr unchanged; with tmoLimit=0 the grant holds for 300 cycles.
REQ-038 Reset mid-cycle: rst_n pulled low while BUSY -> grant=0 immediately (asynchronously); a cycDone pulse after reset has no effect.

Source files
------------

// File: rtl/mbox_cyc_arb.sv
// MBOX cycle arbiter: grants one requester at a time, fixed-priority or round-robin,
// with retry back-off, retry priority and a cycle timeout.
module mbox_cyc_arb #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned RR_MODE   = 1,
   parameter int unsigned TMO_W     = 8,
   parameter int unsigned RETRY_DLY = 2,
   localparam int unsigned IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic             cycDone,
   input  logic             retry,
   input  logic [TMO_W-1:0] tmoLimit,
   output logic [NREQ-1:0]  grant,
   output logic [IW-1:0]    grantIdx,
   output logic             cycActive,
   output logic             tmoErr
);

   typedef enum logic [1:0] {StIdle, StBusy, StBackoff} state_e;

   state_e           state_q, state_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [IW-1:0]    gidx_q, gidx_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]    ridx_q, ridx_d;
   logic             rflag_q, rflag_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [3:0]       bo_cnt_q, bo_cnt_d;
   logic             tmo_err_q, tmo_err_d;

   logic [IW-1:0]    win;
   logic [TMO_W-1:0] tmo_inc;
   logic             tmo_hit;

   // First set request at or after start, wrapping modulo NREQ.
   function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r, input logic [IW-1:0] start);
      logic [IW-1:0] jj;
      pick = start;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         int j;
         j = int'(start) + i;
         if (j >= int'(NREQ)) j = j - int'(NREQ);
         jj = j[IW-1:0];
         if (r[jj]) pick = jj;
      end
   endfunction

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gidx_d    = gidx_q;
      rr_ptr_d  = rr_ptr_q;
      ridx_d    = ridx_q;
      rflag_d   = rflag_q;
      tmo_cnt_d = tmo_cnt_q;
      bo_cnt_d  = bo_cnt_q;
      tmo_err_d = 1'b0;

      win = pick(req, (RR_MODE != 0) ? rr_ptr_q : '0);
      if (rflag_q && req[ridx_q]) win = ridx_q;

      tmo_inc = (tmo_cnt_q == {TMO_W{1'b1}}) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
      tmo_hit = (tmoLimit != '0) && (tmo_inc == tmoLimit);

      case (state_q)
         StIdle: begin
            if (|req) begin
               state_d      = StBusy;
               grant_d      = '0;
               grant_d[win] = 1'b1;
               gidx_d       = win;
               tmo_cnt_d    = '0;
               rflag_d      = 1'b0;
            end
         end
         StBusy: begin
            tmo_cnt_d = tmo_inc;
            // cycDone takes precedence over retry, retry over timeout.
            if (cycDone) begin
               state_d  = StIdle;
               grant_d  = '0;
               gidx_d   = '0;
               rr_ptr_d = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
            end else if (retry) begin
               state_d  = StBackoff;
               grant_d  = '0;
               gidx_d   = '0;
               ridx_d   = gidx_q;
               bo_cnt_d = 4'(RETRY_DLY);
            end else if (tmo_hit) begin
               state_d   = StIdle;
               grant_d   = '0;
               gidx_d    = '0;
               tmo_err_d = 1'b1;
            end
         end
         StBackoff: begin
            bo_cnt_d = bo_cnt_q - 1'b1;
            if (bo_cnt_q <= 4'd1) begin
               bo_cnt_d = '0;
               state_d  = StIdle;
               rflag_d  = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
            gidx_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         gidx_q    <= '0;
         rr_ptr_q  <= '0;
         ridx_q    <= '0;
         rflag_q   <= 1'b0;
         tmo_cnt_q <= '0;
         bo_cnt_q  <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         gidx_q    <= gidx_d;
         rr_ptr_q  <= rr_ptr_d;
         ridx_q    <= ridx_d;
         rflag_q   <= rflag_d;
         tmo_cnt_q <= tmo_cnt_d;
         bo_cnt_q  <= bo_cnt_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign grant     = grant_q;
   assign grantIdx  = gidx_q;
   assign cycActive = (state_q == StBusy);
   assign tmoErr    = tmo_err_q;

endmodule

// File: tb/tb_mbox_cyc_arb.sv
// Directed bench for mbox_cyc_arb: a round-robin instance and a fixed-priority instance
// share clock and reset but have separate request/handshake inputs.
module tb_mbox_cyc_arb;

   localparam int unsigned NREQ = 4;
   localparam int unsigned TMO_W = 8;

   logic             clk;
   logic             rst_n;
   logic [TMO_W-1:0] tmoLimit;

   logic [NREQ-1:0] req_r, grant_r;
   logic            done_r, retry_r, act_r, terr_r;
   logic [1:0]      idx_r;

   logic [NREQ-1:0] req_f, grant_f;
   logic            done_f, retry_f, act_f, terr_f;
   logic [1:0]      idx_f;

   int total = 0;
   int bad   = 0;

   mbox_cyc_arb #(.NREQ(NREQ), .RR_MODE(1), .TMO_W(TMO_W), .RETRY_DLY(2)) u_rr (
      .clk(clk), .rst_n(rst_n), .req(req_r), .cycDone(done_r), .retry(retry_r),
      .tmoLimit(tmoLimit), .grant(grant_r), .grantIdx(idx_r), .cycActive(act_r),
      .tmoErr(terr_r)
   );

   mbox_cyc_arb #(.NREQ(NREQ), .RR_MODE(0), .TMO_W(TMO_W), .RETRY_DLY(2)) u_fp (
      .clk(clk), .rst_n(rst_n), .req(req_f), .cycDone(done_f), .retry(retry_f),
      .tmoLimit(tmoLimit), .grant(grant_f), .grantIdx(idx_f), .cycActive(act_f),
      .tmoErr(terr_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int hold_err;
      rst_n = 1'b0; tmoLimit = '0;
      req_r = '0; done_r = 1'b0; retry_r = 1'b0;
      req_f = '0; done_f = 1'b0; retry_f = 1'b0;
      tick(); tick();
      chk("rst_grant", 32'(grant_r), 0);
      chk("rst_act", 32'(act_r), 0);
      chk("rst_idx", 32'(idx_r), 0);
      chk("rst_terr", 32'(terr_r), 0);
      chk("rst_grant_fp", 32'(grant_f), 0);
      rst_n = 1'b1;
      tick();

      // Round-robin order with req held
      req_r = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         int e;
         e = k % 4;
         chk($sformatf("rr_grant%0d", k), 32'(grant_r), 32'(1 << e));
         chk($sformatf("rr_idx%0d", k), 32'(idx_r), 32'(e));
         chk($sformatf("rr_act%0d", k), 32'(act_r), 1);
         tick();
         done_r = 1'b1;
         tick();
         done_r = 1'b0;
         chk($sformatf("rr_gap%0d", k), 32'(grant_r), 0);
         if (k == 4) req_r = '0;
         tick();
      end
      chk("rr_stop", 32'(grant_r), 0);   // rr_ptr now 1

      // Fixed priority
      req_f = 4'b1010;
      tick();
      chk("fp_grant_a", 32'(grant_f), 32'b0010);
      done_f = 1'b1;
      tick();
      done_f = 1'b0; req_f = 4'b1000;
      chk("fp_gap", 32'(grant_f), 0);
      tick();
      chk("fp_grant_b", 32'(grant_f), 32'b1000);
      chk("fp_idx_b", 32'(idx_f), 3);
      done_f = 1'b1;
      tick();
      done_f = 1'b0; req_f = '0;
      chk("fp_idle", 32'(grant_f), 0);

      // Retry priority overrides fixed priority
      req_f = 4'b0100;
      tick();
      chk("rt_grant", 32'(grant_f), 32'b0100);
      req_f = 4'b0101; retry_f = 1'b1;
      tick();
      retry_f = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rt_off%0d", k), 32'(grant_f), 0);
         chk($sformatf("rt_act%0d", k), 32'(act_f), 0);
         tick();
      end
      chk("rt_regrant", 32'(grant_f), 32'b0100);
      chk("rt_idx", 32'(idx_f), 2);
      done_f = 1'b1;
      tick();
      done_f = 1'b0;
      chk("rt_gap", 32'(grant_f), 0);
      tick();
      chk("rt_flag_clr", 32'(grant_f), 32'b0001);
      done_f = 1'b1;
      tick();
      done_f = 1'b0; req_f = '0;
      tick();

      // Simultaneous done/retry: done wins, pointer advances
      req_r = 4'b1111;
      tick();
      chk("dr_grant", 32'(idx_r), 1);
      done_r = 1'b1; retry_r = 1'b1;
      tick();
      done_r = 1'b0; retry_r = 1'b0;
      chk("dr_gap", 32'(grant_r), 0);
      chk("dr_act", 32'(act_r), 0);
      tick();
      chk("dr_next", 32'(grant_r), 32'b0100);
      done_r = 1'b1;
      tick();
      done_r = 1'b0; req_r = '0;
      tick();   // rr_ptr now 3

      // Timeout after 5 cycles, pointer held
      tmoLimit = 8'd5; req_r = 4'b0001;
      tick();
      chk("to_grant", 32'(grant_r), 32'b0001);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("to_wait%0d", k), 32'({terr_r, grant_r}), 32'b00001);
      end
      tick();
      chk("to_err", 32'(terr_r), 1);
      chk("to_clr", 32'(grant_r), 0);
      req_r = 4'b0011;
      tick();
      chk("to_pulse", 32'(terr_r), 0);
      chk("to_ptr", 32'(idx_r), 0);
      done_r = 1'b1;
      tick();
      done_r = 1'b0; req_r = '0;
      tick();   // rr_ptr now 1

      // Timeout disabled: grant holds
      tmoLimit = '0; req_r = 4'b0100;
      tick();
      hold_err = 0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (grant_r !== 4'b0100 || terr_r !== 1'b0) hold_err++;
      end
      chk("hold_err", 32'(hold_err), 0);
      chk("hold_grant", 32'(grant_r), 32'b0100);
      done_r = 1'b1;
      tick();
      done_r = 1'b0; req_r = '0;
      tick();   // rr_ptr now 3

      // Asynchronous reset mid-cycle
      req_r = 4'b0001;
      tick();
      chk("ar_grant", 32'(grant_r), 32'b0001);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_async", 32'(grant_r), 0);
      chk("ar_act", 32'(act_r), 0);
      req_r = '0;
      tick();
      rst_n = 1'b1;
      done_r = 1'b1;
      tick();
      done_r = 1'b0;
      tick();
      chk("ar_done_ign", 32'({act_r, terr_r, grant_r}), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
